// File: rtl/brent_frame_accumulator.sv
// ============================================================================
// brent_frame_accumulator
// ----------------------------------------------------------------------------
// Purpose:
//   Accumulates frames of COUNT_N unsigned 16-bit samples into a
//   (16+HI_W)-bit total. The low word is summed through a 16-bit Brent-Kung
//   adder (XVIbitbrent). Its carry-out increments an HI_W-bit upper counter.
//   The finished total is presented on a valid/ready port. The block does
//   not accept samples until that total has been handed off.
//
// Parameters:
//   COUNT_N : samples per frame (2..65535)
//   HI_W    : width of the upper carry counter (total width = 16+HI_W)
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous frame abort (ignored while a total is held)
//   in_valid     in   in_data valid
//   in_ready     out  a sample can be accepted this cycle
//   in_data      in   16-bit unsigned sample
//   out_valid    out  frame total available
//   out_ready    in   downstream accepts the total
//   out_sum      out  frame total {acc_hi, acc_lo}
//   out_overflow out  a carry was lost out of acc_hi during the frame
//
// Build option:
//   BRENT_ACC_SATURATE_EN - when defined, an overflowed frame reports an
//   all-ones total. When undefined, the total wraps modulo 2^(16+HI_W).
// ============================================================================

// 16-bit Brent-Kung prefix adder: sum = A + B, cout = carry out of bit 15.
module XVIbitbrent (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] sum,
    output logic        cout
);

    // Brent-Kung carry tree. The up-sweep builds power-of-two block prefixes.
    // The down-sweep fills in the remaining positions. Both sweeps update in
    // place, because each step reads only a lower index that is already final
    // for the span it needs.
    function automatic logic [16:0] bk_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] hp;
        logic [15:0] c;
        int          s;
        g  = a & b;
        p  = a | b;
        hp = a ^ b;
        for (int l = 0; l < 4; l++) begin
            s = 2 << l;
            for (int i = s - 1; i < 16; i += s) begin
                g[i] = g[i] | (p[i] & g[i - (s >> 1)]);
                p[i] = p[i] & p[i - (s >> 1)];
            end
        end
        for (int l = 2; l >= 0; l--) begin
            s = 2 << l;
            for (int i = s + (s >> 1) - 1; i < 16; i += s) begin
                g[i] = g[i] | (p[i] & g[i - (s >> 1)]);
                p[i] = p[i] & p[i - (s >> 1)];
            end
        end
        // g[i] now holds the carry out of bit i.
        c = {g[14:0], 1'b0};
        return {g[15], hp ^ c};
    endfunction

    logic [16:0] res_s;

    // Purely combinational add.
    always_comb begin
        res_s = bk_add(A, B);
    end

    assign sum  = res_s[15:0];
    assign cout = res_s[16];

endmodule

module brent_frame_accumulator #(
    parameter int COUNT_N = 8,
    parameter int HI_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [16+HI_W-1:0] out_sum,
    output logic               out_overflow
);

    localparam int TOT_W = 16 + HI_W;
    localparam logic [15:0] LAST_CNT = 16'(COUNT_N - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       acc_lo_q, acc_lo_d;
    logic [HI_W-1:0]   acc_hi_q, acc_hi_d;
    logic [15:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [TOT_W-1:0]  out_sum_q, out_sum_d;
    logic              out_ovf_q, out_ovf_d;

    logic [15:0]       add_sum_s;
    logic              add_cout_s;
    logic              accept_s;
    logic [HI_W-1:0]   hi_inc_s;
    logic              ovf_next_s;
    logic [TOT_W-1:0]  total_s;

    XVIbitbrent u_adder (
        .A    (acc_lo_q),
        .B    (in_data),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_HOLD);
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;
    assign accept_s     = in_valid & in_ready;

    // Upper-word update, sticky lost-carry flag and the frame total that would
    // be presented if this accept closes the frame.
    always_comb begin
        hi_inc_s   = acc_hi_q + HI_W'(add_cout_s);
        ovf_next_s = ovf_q | ((&acc_hi_q) & add_cout_s);
`ifdef BRENT_ACC_SATURATE_EN
        if (ovf_next_s) begin
            total_s = {TOT_W{1'b1}};
        end else begin
            total_s = {hi_inc_s, add_sum_s};
        end
`else
        total_s = {hi_inc_s, add_sum_s};
`endif
    end

    // Next-state logic for the ACCUM/HOLD controller and the accumulator.
    always_comb begin
        state_d   = state_q;
        acc_lo_d  = acc_lo_q;
        acc_hi_d  = acc_hi_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (clear) begin
                    // Abort the frame. A sample offered in the same cycle is dropped.
                    acc_lo_d = 16'd0;
                    acc_hi_d = {HI_W{1'b0}};
                    count_d  = 16'd0;
                    ovf_d    = 1'b0;
                end else if (accept_s) begin
                    acc_lo_d = add_sum_s;
                    acc_hi_d = hi_inc_s;
                    count_d  = count_q + 16'd1;
                    ovf_d    = ovf_next_s;
                    if (count_q == LAST_CNT) begin
                        out_sum_d = total_s;
                        out_ovf_d = ovf_next_s;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d   = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                // The presented total survives clear and is released only by
                // the handshake.
                if (out_ready) begin
                    acc_lo_d = 16'd0;
                    acc_hi_d = {HI_W{1'b0}};
                    count_d  = 16'd0;
                    ovf_d    = 1'b0;
                    state_d  = ST_ACCUM;
                end else begin
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                state_d  = ST_ACCUM;
                acc_lo_d = 16'd0;
                acc_hi_d = {HI_W{1'b0}};
                count_d  = 16'd0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ACCUM;
            acc_lo_q  <= 16'd0;
            acc_hi_q  <= {HI_W{1'b0}};
            count_q   <= 16'd0;
            ovf_q     <= 1'b0;
            out_sum_q <= {TOT_W{1'b0}};
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_lo_q  <= acc_lo_d;
            acc_hi_q  <= acc_hi_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_brent_frame_accumulator.sv
// Self-checking bench for brent_frame_accumulator.
// Inputs change and outputs are sampled on the falling edge of clk.
// Expected frame totals come from a software model. They are queued when the
// frame's last sample is driven, and they are popped when the DUT presents
// the frame total.
module tb_brent_frame_accumulator;

    localparam int HI_W  = 8;
    localparam int TOT_W = 16 + HI_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [TOT_W-1:0]  out_sum;
    logic              out_overflow;

    logic              b_in_valid;
    logic              b_in_ready;
    logic [15:0]       b_in_data;
    logic              b_out_valid;
    logic              b_out_ready;
    logic [TOT_W-1:0]  b_out_sum;
    logic              b_out_overflow;
    logic              b_clear;

    int n_cmp  = 0;
    int n_fail = 0;

    longint            model_acc;
    int                model_cnt;
    logic [TOT_W:0]    exp_q[$];
    logic [TOT_W:0]    exp_item;
    logic [TOT_W-1:0]  held_sum;

    always #5 clk = ~clk;

    brent_frame_accumulator #(.COUNT_N(8), .HI_W(HI_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_overflow(out_overflow)
    );

    brent_frame_accumulator #(.COUNT_N(512), .HI_W(HI_W)) dut_big (
        .clk(clk), .reset_n(reset_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_overflow(b_out_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected {overflow, total} for a true (unbounded) frame sum.
    function automatic logic [TOT_W:0] model_result(input longint total);
        logic ovf;
        logic [TOT_W-1:0] s;
        ovf = (total >= (64'd1 << TOT_W));
        s   = total[TOT_W-1:0];
`ifdef BRENT_ACC_SATURATE_EN
        if (ovf) s = {TOT_W{1'b1}};
`endif
        return {ovf, s};
    endfunction

    task automatic model_reset();
        model_acc = 0;
        model_cnt = 0;
    endtask

    // Offer one sample to the COUNT_N=8 DUT for one cycle. It must be accepted.
    task automatic send(input logic [15:0] d);
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        model_acc += longint'(d);
        model_cnt++;
        if (model_cnt == 8) begin
            exp_q.push_back(model_result(model_acc));
            model_reset();
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a total, compare it with the scoreboard, then handshake.
    task automatic collect(input string tag);
        int waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp_item = exp_q.pop_front();
            check({tag, "_sum"}, 32'(out_sum), 32'(exp_item[TOT_W-1:0]));
            check({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, exp_item[TOT_W]});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 16'd77; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'd0; b_out_ready = 1'b0; b_clear = 1'b0;
        model_reset();

        // Reset with in_valid high.
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", {31'd0, out_overflow}, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame discards the partial sum.
        for (int i = 0; i < 3; i++) send(16'd500);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(16'd1);
        collect("reset_mid_frame");

        // Carry chain. out_valid must rise on the cycle after the last accept.
        begin
            logic [15:0] cc[8];
            cc = '{16'd32767, 16'd64, 16'd128, 16'd16384, 16'd16, 16'd4, 16'd32768, 16'd1};
            for (int i = 0; i < 8; i++) send(cc[i]);
        end
        check("carry_latency", {31'd0, out_valid}, 32'd1);
        collect("carry_chain");

        // Maximum sample value, with a gap inside the frame.
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        collect("max_words");

        // Backpressure: samples offered while a total is held are not consumed.
        for (int i = 0; i < 8; i++) send(16'd1000);
        held_sum = out_sum;
        in_valid = 1'b1;
        in_data  = 16'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum_stable", 32'(out_sum), 32'(held_sum));
        end
        // The handshake cycle must not accept the offered sample either.
        collect("backpressure");
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd3);
        collect("after_backpressure");

        // Abort: clear drops the partial frame and the simultaneous sample.
        for (int i = 0; i < 3; i++) send(16'd1000);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd500;
        model_reset();
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd2);
        collect("abort");

        // clear while a total is held is ignored.
        for (int i = 0; i < 8; i++) send(16'd7);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_clear_valid", {31'd0, out_valid}, 32'd1);
        clear = 1'b0;
        collect("hold_clear");

        // Overflow with COUNT_N=512 and every sample 65535.
        b_in_valid = 1'b1;
        b_in_data  = 16'hFFFF;
        for (int i = 0; i < 512; i++) @(negedge clk);
        b_in_valid = 1'b0;
        check("big_latency", {31'd0, b_out_valid}, 32'd1);
        exp_item = model_result(longint'(512) * longint'(65535));
        check("big_sum", 32'(b_out_sum), 32'(exp_item[TOT_W-1:0]));
        check("big_ovf", {31'd0, b_out_overflow}, {31'd0, exp_item[TOT_W]});
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("big_released", {31'd0, b_in_ready}, 32'd1);

        // After an overflowed frame, the next frame starts with no carry.
        b_in_valid = 1'b1;
        b_in_data  = 16'd1;
        for (int i = 0; i < 512; i++) @(negedge clk);
        b_in_valid = 1'b0;
        check("big2_sum", 32'(b_out_sum), 32'd512);
        check("big2_ovf", {31'd0, b_out_overflow}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
